// File: rtl/pixel_write_sequencer.sv
// pixel_write_sequencer: Avalon-MM pixel command FIFO draining (x, y, colour) into the framebuffer write port
module pixel_write_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               fb_req,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ack,
    output logic [3:0]         status,
    output logic               irq
);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CMD_W = 19 + COLOR_W;

    typedef enum logic [1:0] {IDLE, CALC, REQ} state_t;

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  mem [FIFO_DEPTH];
    logic [CMD_W-1:0]  cur;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [15:0]       done_count;
    logic              enable, irq_en, range_err, ovf_err;
    logic              reg_wr, pix_wr, ctrl_wr, done_wr, range_bad, range_set, ovf_set;
    logic              push, pop, fire, empty, full, busy, err;
    logic              unused_bits;

    assign reg_wr    = chipselect & ~write_n;
    assign pix_wr    = reg_wr & (address == 2'd0);
    assign ctrl_wr   = reg_wr & (address == 2'd1);
    assign done_wr   = reg_wr & (address == 2'd3);
    assign range_bad = ({22'd0, writedata[9:0]} >= H_RES) || ({23'd0, writedata[18:10]} >= V_RES);
    // full is sampled before this cycle's pop, so a push into a full FIFO is dropped even while draining
    assign range_set = pix_wr & range_bad;
    assign ovf_set   = pix_wr & ~range_bad & full;
    assign push      = pix_wr & ~range_bad & ~full;
    assign empty     = count == '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign pop       = (state_q == IDLE) & enable & ~empty;
    assign fire      = (state_q == REQ) & fb_ack;
    assign busy      = state_q != IDLE;
    assign err       = range_err | ovf_err;
    assign status    = {err, busy, full, empty};
    assign fb_req    = state_q == REQ;
    assign unused_bits = ^writedata[31:CMD_W];

    assign readdata = address == 2'd1 ? {30'd0, irq_en, enable} :
                      address == 2'd2 ? {16'd0, 8'(count), 2'd0, ovf_err, range_err, status} :
                      address == 2'd3 ? {16'd0, done_count} : 32'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pop ? CALC : IDLE;
            CALC:    state_d = REQ;
            REQ:     state_d = fb_ack ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
    end

    // Commands are stored in their bus layout {colour, y, x}
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata[CMD_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cur        <= '0;
            fb_addr    <= '0;
            fb_data    <= '0;
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            range_err  <= 1'b0;
            ovf_err    <= 1'b0;
            done_count <= '0;
            irq        <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count      <= count + CW'(push) - CW'(pop);
            cur        <= pop ? mem[rd_ptr] : cur;
            fb_addr    <= state_q == CALC ? ADDR_W'(cur[18:10]) * ADDR_W'(H_RES) + ADDR_W'(cur[9:0]) : fb_addr;
            fb_data    <= state_q == CALC ? cur[CMD_W-1:19] : fb_data;
            enable     <= ctrl_wr ? writedata[0] : enable;
            irq_en     <= ctrl_wr ? writedata[1] : irq_en;
            range_err  <= range_set | (range_err & ~(ctrl_wr & writedata[2]));
            ovf_err    <= ovf_set | (ovf_err & ~(ctrl_wr & writedata[3]));
            done_count <= done_wr ? 16'd0 : done_count + 16'(fire);
            irq        <= irq_en & err;
        end
    end
endmodule

// File: tb/tb_pixel_write_sequencer.sv
// tb_pixel_write_sequencer: scoreboard bench for pixel_write_sequencer
module tb_pixel_write_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        fb_req;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_ack = 1'b0;
    logic [3:0]  status;
    logic        irq;

    int total = 0;
    int bad = 0;
    int exp_done = 0;
    logic [18:0] sb_addr[$];
    logic [11:0] sb_data[$];

    pixel_write_sequencer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack),
        .status(status), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        chipselect = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic push_pix(input int x, input int y, input int c, input bit q);
        bus_write(2'd0, (32'(c) << 19) | (32'(y) << 10) | 32'(x));
        if (q) begin
            sb_addr.push_back(19'(y * 640 + x));
            sb_data.push_back(12'(c));
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!fb_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = fb_req;
        if (!ok) check("req_timeout", 32'(fb_req), 1);
    endtask

    task automatic pop_cmp(output logic [18:0] ea, output logic [11:0] ed);
        ea = '1;
        ed = '1;
        if (sb_addr.size() > 0) begin
            ea = sb_addr.pop_front();
            ed = sb_data.pop_front();
        end
        check("fb_addr", 32'(fb_addr), 32'(ea));
        check("fb_data", 32'(fb_data), 32'(ed));
    endtask

    task automatic hold_chk(input int n, input logic [18:0] ea, input logic [11:0] ed);
        repeat (n) begin
            @(negedge clk);
            check("hold_req", 32'(fb_req), 1);
            check("hold_addr", 32'(fb_addr), 32'(ea));
            check("hold_data", 32'(fb_data), 32'(ed));
        end
    endtask

    task automatic ack_pulse();
        fb_ack = 1'b1;
        @(negedge clk);
        fb_ack = 1'b0;
        exp_done++;
        check("req_drop", 32'(fb_req), 0);
    endtask

    task automatic take(input int hold);
        bit ok;
        logic [18:0] ea;
        logic [11:0] ed;
        wait_req(ok);
        if (ok) begin
            pop_cmp(ea, ed);
            hold_chk(hold, ea, ed);
            ack_pulse();
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        logic [18:0] ea;
        logic [11:0] ed;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(fb_req), 0);
        check("rst_status", 32'(status), 1);
        check("rst_irq", 32'(irq), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single pixel, latency and address mapping
        rd_chk("t1_stat", 2'd2, 32'h1);
        bus_write(2'd1, 32'h1);
        push_pix(3, 2, 12'hABC, 1);
        check("t1_lat0", 32'(fb_req), 0);
        @(negedge clk);
        check("t1_lat1", 32'(fb_req), 0);
        @(negedge clk);
        check("t1_lat2", 32'(fb_req), 1);
        check("t1_addr_const", 32'(fb_addr), 1283);
        take(0);
        rd_chk("t1_done", 2'd3, 32'(exp_done));
        rd_chk("t1_stat2", 2'd2, 32'h1);

        // 2: overflow while disabled, then ordered drain
        bus_write(2'd3, 32'h0);
        exp_done = 0;
        rd_chk("t2_done_clr", 2'd3, 32'h0);
        bus_write(2'd1, 32'h0);
        for (int i = 0; i < 9; i++) push_pix(10 + i, 20 + i, 12'h100 + i, i < 8);
        rd_chk("t2_stat_full", 2'd2, 32'h0000_082A);
        bus_write(2'd1, 32'h1);
        for (int i = 0; i < 8; i++) take(0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= fb_req;
        end
        check("t2_no_extra", 32'(seen), 0);
        rd_chk("t2_done", 2'd3, 32'(exp_done));
        bus_write(2'd1, 32'h9);
        rd_chk("t2_ovf_clr", 2'd2, 32'h1);

        // 3: range errors, irq, and boundary pixel
        bus_write(2'd1, 32'h3);
        push_pix(640, 0, 12'h123, 0);
        check("t3_irq_lag", 32'(irq), 0);
        @(negedge clk);
        check("t3_irq", 32'(irq), 1);
        rd_chk("t3_stat", 2'd2, 32'h19);
        push_pix(0, 480, 12'h124, 0);
        rd_chk("t3_stat_y", 2'd2, 32'h19);
        bus_write(2'd1, 32'h7);
        check("t3_irq_hold", 32'(irq), 1);
        rd_chk("t3_stat_clr", 2'd2, 32'h1);
        @(negedge clk);
        check("t3_irq_clr", 32'(irq), 0);
        push_pix(639, 479, 12'h5A5, 1);
        take(0);

        // 4: stalled request, disable mid-REQ
        bus_write(2'd1, 32'h0);
        push_pix(100, 50, 12'h111, 1);
        push_pix(5, 6, 12'h222, 1);
        push_pix(7, 8, 12'h333, 1);
        bus_write(2'd1, 32'h1);
        wait_req(ok);
        if (ok) begin
            pop_cmp(ea, ed);
            hold_chk(5, ea, ed);
            bus_write(2'd1, 32'h0);
            hold_chk(5, ea, ed);
            ack_pulse();
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= fb_req;
        end
        check("t4_no_req", 32'(seen), 0);
        rd_chk("t4_stat", 2'd2, 32'h0000_0200);

        // 5: push/pop same cycle, and push into full FIFO during pop
        push_pix(9, 9, 12'h444, 1);
        push_pix(10, 10, 12'h555, 1);
        bus_write(2'd1, 32'h1);
        push_pix(11, 11, 12'h666, 1);
        rd_chk("t5_count4", 2'd2, 32'h0000_0404);
        bus_write(2'd1, 32'h0);
        take(0);
        for (int i = 0; i < 4; i++) push_pix(20 + i, 30 + i, 12'h700 + i, 1);
        rd_chk("t5_full", 2'd2, 32'h0000_0802);
        bus_write(2'd1, 32'h1);
        push_pix(1, 1, 12'h777, 0);
        rd_chk("t5_ovf", 2'd2, 32'h0000_072C);
        while (sb_addr.size() > 0) take(0);
        rd_chk("t5_done", 2'd3, 32'(exp_done));

        // 6: async reset mid-REQ
        push_pix(2, 3, 12'h999, 1);
        wait_req(ok);
        if (ok) pop_cmp(ea, ed);
        #2 reset_n = 1'b0;
        #1 check("t6_async_req", 32'(fb_req), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_done = 0;
        sb_addr.delete();
        sb_data.delete();
        @(negedge clk);
        rd_chk("t6_stat", 2'd2, 32'h1);
        rd_chk("t6_done", 2'd3, 32'(exp_done));
        check("t6_irq", 32'(irq), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_write_sequencer.md
Name: pixel_write_sequencer

Overview:
Avalon-MM slave that accepts pixel write commands (x, y, colour) from the Nios host and queues them in a small FIFO. It drains the queue into the VGA framebuffer write port using a req/ack handshake, converting (x, y) to a linear address. It drives a 4-bit status bus to the pixel-status PIO path and raises an interrupt on errors. It sits between the host bus and the framebuffer write port.

Parameters:
FIFO_DEPTH  8    command FIFO entries; power of 2, minimum 2
H_RES       640  visible width in pixels; x must be < H_RES
V_RES       480  visible height in lines; y must be < V_RES
ADDR_W      19   framebuffer address width; must satisfy H_RES*V_RES <= 2^ADDR_W
COLOR_W     12   pixel colour width; must be <= 12

Ports:
clk         in   1        system clock
reset_n     in   1        asynchronous active-low reset
address     in   2        register select
chipselect  in   1        slave select
write_n     in   1        active-low write strobe
writedata   in   32       write data
readdata    out  32       combinational read data
fb_req      out  1        framebuffer write request
fb_addr     out  ADDR_W   linear pixel address, y*H_RES+x
fb_data     out  COLOR_W  pixel colour
fb_ack      in   1        framebuffer accepts the write
status      out  4        {err, busy, full, empty}
irq         out  1        level interrupt

Behaviour:
- Reset is asynchronous, active-low (reset_n); clock is clk.
- Reset values: FIFO empty, FSM IDLE, fb_req=0, fb_addr=0, fb_data=0, enable=0, irq_en=0, errors=0, done_count=0, status=4'b0001, irq=0.
- Register map (a register write is chipselect & ~write_n):
  - addr0 PIXEL (write): x=wd[9:0], y=wd[18:10], colour=wd[19+COLOR_W-1:19]. Reads return 0.
  - addr1 CTRL: bit0 enable, bit1 irq_en. Writing 1 to bit2 clears range_err; writing 1 to bit3 clears ovf_err. Bits 2 and 3 read as 0.
  - addr2 STAT (read-only): [3:0] status, [4] range_err, [5] ovf_err, [15:8] FIFO count.
  - addr3 DONE: [15:0] completed-write counter. Any write clears it. The counter wraps at 16 bits.
- Write to PIXEL:
  - If x >= H_RES or y >= V_RES: command dropped, range_err set (sticky).
  - Else if FIFO is full: command dropped, ovf_err set (sticky).
  - Else: command pushed.
  - full is evaluated before any same-cycle pop, so a push into a full FIFO is dropped even if a pop occurs that cycle.
  - If both errors apply, only range_err is set.
- FSM states:
  - IDLE: if enable & ~empty, pop the head and go to CALC.
  - CALC: register fb_addr = y*H_RES + x (computed in ADDR_W bits) and fb_data = colour; go to REQ.
  - REQ: fb_req=1; fb_addr and fb_data stay stable. On fb_ack, increment done_count and go to IDLE; fb_req is 0 from the next cycle.
- Latency: fb_req rises 2 cycles after the pop cycle. Back-to-back throughput is one pixel per 3 cycles when fb_ack returns immediately.
- fb_ack is ignored outside REQ.
- Clearing enable mid-transfer: the current REQ completes; no further pops occur. Queued commands are retained.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- Simultaneous CTRL error-clear and a new error of the same type in the same cycle: the set wins.
- Status bits: busy = (state != IDLE); empty and full reflect the FIFO; err = range_err | ovf_err.
- irq = irq_en & err, registered (1-cycle delay).
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset mid-REQ: fb_req drops immediately (asynchronous); the queue is lost.

Test Plan:
1. After reset, read STAT -> 0x00000001. Set enable, push (x=3, y=2, colour=0xABC) -> fb_req rises 2 cycles after the pop with fb_addr=1283, fb_data=0xABC. Ack -> DONE=1, status=0001.
2. enable=0, push 9 valid pixels with FIFO_DEPTH=8 -> count=8, full=1, ovf_err=1, status=1010. Set enable, ack every request -> exactly 8 writes in FIFO order, DONE=8.
3. Push x=640, y=0 -> dropped, range_err=1; with irq_en=1, irq=1 one cycle later. Write CTRL bit2=1 -> range_err=0, irq=0.
4. Hold fb_ack low for 10 cycles in REQ -> fb_req, fb_addr and fb_data stable throughout. Clear enable mid-REQ, then ack -> write completes, no further fb_req, queue count retained.
5. Pop and push in the same cycle at count=4 -> count stays 4. Push to a full FIFO in the pop cycle -> dropped, ovf_err=1.
6. Assert reset_n low while fb_req=1 -> fb_req=0 asynchronously. After release: status=0001, DONE=0.
